shared_tlb: RTL and testbench

- Second-level, fully associative TLB shared by NPORTS first-level TLB miss ports (ITLB, DTLB, and others).
- Sits between the L1 TLB miss paths and the HPTW.
- Adds over the per-MMU TLB:
  - round-robin multi-port lookup;
  - registered 1-cycle hit/miss response;
  - HPTW fill port with invalid-first / tree-PLRU replacement;
  - selective sfence.vma flush by ASID and/or VPN, honouring global entries.
- Miss response tells the requester to start an HPTW walk.

---
 rtl/shared_tlb_pkg.sv | 33 +++
 rtl/shared_tlb_plru.sv | 48 ++++
 rtl/shared_tlb.sv | 213 +++++++++++++++++++++
 tb/tb_shared_tlb.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shared_tlb_pkg.sv
// Shared types for the second-level TLB: core configuration,
// page-level and sfence.vma flush-mode encodings.
package shared_tlb_pkg;

    typedef struct packed {
        int XLEN;
        int ASID_BITS;
        int PPN_BITS;
    } cvw_t;

    localparam cvw_t CVW_DEFAULT = '{
        XLEN:      64,
        ASID_BITS: 16,
        PPN_BITS:  44
    };

    typedef enum logic [1:0] {
        PT_4K   = 2'd0,
        PT_MEGA = 2'd1,
        PT_GIGA = 2'd2,
        PT_TERA = 2'd3
    } tlb_page_t;

    typedef enum logic [1:0] {
        FL_ALL  = 2'd0,
        FL_ASID = 2'd1,
        FL_VPN  = 2'd2,
        FL_BOTH = 2'd3
    } flush_mode_t;

    localparam int G_BIT = 5;

endpackage

// File: rtl/shared_tlb_plru.sv
// Tree pseudo-LRU over ENTRIES ways (ENTRIES-1 node bits).
// Ports: touch_valid/touch_idx mark a way as recently used; victim names the way to evict.
module shared_tlb_plru #(
    parameter int ENTRIES = 32,
    parameter int IW      = $clog2(ENTRIES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          touch_valid,
    input  logic [IW-1:0] touch_idx,
    output logic [IW-1:0] victim
);

    // Heap layout: node n has children 2n+1 (lower half) and 2n+2.
    // A node bit of 1 means the victim lies in the upper half.
    logic [ENTRIES-2:0] bits_q;
    logic [ENTRIES-2:0] bits_d;
    int                 vnode;
    int                 tnode;

    always_comb begin
        victim = '0;
        vnode  = 0;
        for (int l = 0; l < IW; l++) begin
            victim[IW-1-l] = bits_q[vnode];
            vnode = 2 * vnode + 1 + int'(bits_q[vnode]);
        end
    end

    // Point every node on the touched path away from the touched way.
    always_comb begin
        bits_d = bits_q;
        tnode  = 0;
        for (int l = 0; l < IW; l++) begin
            bits_d[tnode] = ~touch_idx[IW-1-l];
            tnode = 2 * tnode + 1 + int'(touch_idx[IW-1-l]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bits_q <= '0;
        end else if (touch_valid) begin
            bits_q <= bits_d;
        end
    end

endmodule

// File: rtl/shared_tlb.sv
// Shared fully associative L2 TLB: round-robin lookup from NPORTS L1 miss ports,
// registered hit/miss response, HPTW fill with PLRU replacement, selective sfence.vma flush.
// Ports: Req*/Rsp* lookup path, Fill* HPTW write port, Flush*/FlushDone sfence path.
module shared_tlb
    import shared_tlb_pkg::*;
#(
    parameter cvw_t P        = CVW_DEFAULT,
    parameter int   NPORTS   = 2,
    parameter int   ENTRIES  = 32,
    parameter int   LEVELS   = (P.XLEN == 64) ? 4 : 2,
    parameter int   VPN_BITS = LEVELS * ((P.XLEN == 64) ? 9 : 10)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NPORTS-1:0]          ReqValid,
    output logic [NPORTS-1:0]          ReqReady,
    input  logic [NPORTS*VPN_BITS-1:0] ReqVPN,
    input  logic [P.ASID_BITS-1:0]     ReqASID,
    output logic [NPORTS-1:0]          RspValid,
    output logic                       RspHit,
    output logic [P.XLEN-1:0]          RspPTE,
    output logic [1:0]                 RspPageType,
    input  logic                       FillValid,
    input  logic [VPN_BITS-1:0]        FillVPN,
    input  logic [P.ASID_BITS-1:0]     FillASID,
    input  logic [P.XLEN-1:0]          FillPTE,
    input  logic [1:0]                 FillPageType,
    input  logic                       FlushValid,
    input  logic [1:0]                 FlushMode,
    input  logic [P.ASID_BITS-1:0]     FlushASID,
    input  logic [VPN_BITS-1:0]        FlushVPN,
    output logic                       FlushDone
);

    localparam int SEG = (P.XLEN == 64) ? 9 : 10;
    localparam int IW  = $clog2(ENTRIES);
    localparam int PW  = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    // Bits below the entry's page level are don't-care (superpages).
    function automatic logic [VPN_BITS-1:0] pt_mask(tlb_page_t pt);
        return {VPN_BITS{1'b1}} << (SEG * int'(pt));
    endfunction

    logic [ENTRIES-1:0]    e_valid;
    logic [VPN_BITS-1:0]   e_vpn  [ENTRIES];
    logic [P.ASID_BITS-1:0] e_asid [ENTRIES];
    logic [P.XLEN-1:0]     e_pte  [ENTRIES];
    tlb_page_t             e_pt   [ENTRIES];

    logic [PW-1:0]         rr_q;
    logic [NPORTS-1:0]     grant;
    logic [PW-1:0]         gidx;
    logic                  gvalid;
    logic [VPN_BITS-1:0]   req_vpn;

    logic [ENTRIES-1:0]    match;
    logic                  hit;
    logic [IW-1:0]         hit_idx;

    logic [NPORTS-1:0]     rsp_valid_q;
    logic                  rsp_hit_q;
    logic [P.XLEN-1:0]     rsp_pte_q;
    logic [1:0]            rsp_pt_q;
    logic [IW-1:0]         hit_idx_q;
    logic                  flush_done_q;

    logic                  has_inv;
    logic [IW-1:0]         inv_idx;
    logic [IW-1:0]         plru_victim;
    logic [IW-1:0]         fill_idx;
    logic                  fill_en;

    logic [ENTRIES-1:0]    f_asid;
    logic [ENTRIES-1:0]    f_vpn;
    logic [ENTRIES-1:0]    glob;
    logic [ENTRIES-1:0]    clr;

    // Round-robin arbiter; flush and fill cycles own the array.
    always_comb begin
        grant  = '0;
        gidx   = '0;
        gvalid = 1'b0;
        if (reset && !FlushValid && !FillValid) begin
            for (int k = 0; k < NPORTS; k++) begin
                if (!gvalid && ReqValid[(int'(rr_q) + k) % NPORTS]) begin
                    gvalid = 1'b1;
                    gidx   = PW'((int'(rr_q) + k) % NPORTS);
                    grant[(int'(rr_q) + k) % NPORTS] = 1'b1;
                end
            end
        end
    end

    assign ReqReady = grant;
    assign req_vpn  = ReqVPN[int'(gidx)*VPN_BITS +: VPN_BITS];

    always_comb begin
        match = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            match[i] = e_valid[i]
                     && (e_asid[i] == ReqASID || e_pte[i][G_BIT])
                     && ((e_vpn[i] ^ req_vpn) & pt_mask(e_pt[i])) == '0;
        end
    end

    // Lowest index wins on multiple hits.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end

    always_comb begin
        has_inv = 1'b0;
        inv_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!e_valid[i]) begin
                has_inv = 1'b1;
                inv_idx = IW'(i);
            end
        end
    end

    assign fill_en  = FillValid && !FlushValid;
    assign fill_idx = has_inv ? inv_idx : plru_victim;

    always_comb begin
        f_asid = '0;
        f_vpn  = '0;
        glob   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            f_asid[i] = e_asid[i] == FlushASID;
            f_vpn[i]  = ((e_vpn[i] ^ FlushVPN) & pt_mask(e_pt[i])) == '0;
            glob[i]   = e_pte[i][G_BIT];
        end
    end

    always_comb begin
        clr = '0;
        unique case (flush_mode_t'(FlushMode))
            FL_ALL:  clr = '1;
            FL_ASID: clr = f_asid & ~glob;
            FL_VPN:  clr = f_vpn;
            FL_BOTH: clr = f_vpn & f_asid & ~glob;
            default: clr = '1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_valid <= '0;
        end else if (FlushValid) begin
            e_valid <= e_valid & ~clr;
        end else if (FillValid) begin
            e_valid[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            e_vpn[fill_idx]  <= FillVPN;
            e_asid[fill_idx] <= FillASID;
            e_pte[fill_idx]  <= FillPTE;
            e_pt[fill_idx]   <= tlb_page_t'(FillPageType);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_q         <= '0;
            rsp_valid_q  <= '0;
            rsp_hit_q    <= 1'b0;
            rsp_pte_q    <= '0;
            rsp_pt_q     <= '0;
            hit_idx_q    <= '0;
            flush_done_q <= 1'b0;
        end else begin
            rsp_valid_q  <= grant;
            rsp_hit_q    <= gvalid && hit;
            rsp_pte_q    <= (gvalid && hit) ? e_pte[hit_idx] : '0;
            rsp_pt_q     <= (gvalid && hit) ? e_pt[hit_idx] : 2'd0;
            hit_idx_q    <= hit_idx;
            flush_done_q <= FlushValid;
            if (gvalid) begin
                rr_q <= (int'(gidx) == NPORTS - 1) ? '0 : gidx + 1'b1;
            end
        end
    end

    assign RspValid    = rsp_valid_q;
    assign RspHit      = rsp_hit_q;
    assign RspPTE      = rsp_pte_q;
    assign RspPageType = rsp_pt_q;
    assign FlushDone   = flush_done_q;

    // A fill and a delivered hit can touch in the same cycle; the fill wins
    // so the freshly written way is not immediately the next victim.
    shared_tlb_plru #(
        .ENTRIES(ENTRIES)
    ) u_plru (
        .clk        (clk),
        .reset      (reset),
        .touch_valid(fill_en || rsp_hit_q),
        .touch_idx  (fill_en ? fill_idx : hit_idx_q),
        .victim     (plru_victim)
    );

endmodule

// File: tb/tb_shared_tlb.sv
// Directed bench for shared_tlb with a reference model checked every cycle.
// Ports: none (top-level bench).
module tb_shared_tlb;
    import shared_tlb_pkg::*;

    localparam int NP = 2;
    localparam int NE = 32;
    localparam int VB = 36;
    localparam int XL = 64;
    localparam int AB = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NP-1:0]     req_valid = '0;
    logic [NP-1:0]     req_ready;
    logic [NP*VB-1:0]  req_vpn = '0;
    logic [AB-1:0]     req_asid = '0;
    logic [NP-1:0]     rsp_valid;
    logic              rsp_hit;
    logic [XL-1:0]     rsp_pte;
    logic [1:0]        rsp_pt;
    logic              fill_valid = 1'b0;
    logic [VB-1:0]     fill_vpn = '0;
    logic [AB-1:0]     fill_asid = '0;
    logic [XL-1:0]     fill_pte = '0;
    logic [1:0]        fill_pt = '0;
    logic              flush_valid = 1'b0;
    logic [1:0]        flush_mode = '0;
    logic [AB-1:0]     flush_asid = '0;
    logic [VB-1:0]     flush_vpn = '0;
    logic              flush_done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    shared_tlb dut (
        .clk         (clk),
        .reset       (reset),
        .ReqValid    (req_valid),
        .ReqReady    (req_ready),
        .ReqVPN      (req_vpn),
        .ReqASID     (req_asid),
        .RspValid    (rsp_valid),
        .RspHit      (rsp_hit),
        .RspPTE      (rsp_pte),
        .RspPageType (rsp_pt),
        .FillValid   (fill_valid),
        .FillVPN     (fill_vpn),
        .FillASID    (fill_asid),
        .FillPTE     (fill_pte),
        .FillPageType(fill_pt),
        .FlushValid  (flush_valid),
        .FlushMode   (flush_mode),
        .FlushASID   (flush_asid),
        .FlushVPN    (flush_vpn),
        .FlushDone   (flush_done)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    bit            m_v    [NE];
    logic [VB-1:0] m_vpn  [NE];
    logic [AB-1:0] m_asid [NE];
    logic [XL-1:0] m_pte  [NE];
    int            m_pt   [NE];
    bit            m_tree [NE];   // heap nodes 1..NE-1, 1 = victim in upper half
    int            m_ptr;

    logic [NP-1:0] e_rv;
    logic          e_hit;
    logic [XL-1:0] e_pte;
    logic [1:0]    e_pt;
    int            e_idx;
    logic          e_fd;

    function automatic int plru_victim();
        int node = 1;
        int lo = 0;
        int size = NE;
        while (size > 1) begin
            size = size / 2;
            if (m_tree[node]) begin
                lo = lo + size;
                node = 2 * node + 1;
            end else begin
                node = 2 * node;
            end
        end
        return lo;
    endfunction

    task automatic plru_touch(input int idx);
        int node = 1;
        int lo = 0;
        int size = NE;
        while (size > 1) begin
            size = size / 2;
            if (idx >= lo + size) begin
                m_tree[node] = 1'b0;
                lo = lo + size;
                node = 2 * node + 1;
            end else begin
                m_tree[node] = 1'b1;
                node = 2 * node;
            end
        end
    endtask

    function automatic bit vpn_eq(input logic [VB-1:0] a,
                                  input logic [VB-1:0] b, input int pt);
        return (a >> (9 * pt)) == (b >> (9 * pt));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NE; i++) begin
            m_v[i] = 1'b0;
            m_tree[i] = 1'b0;
        end
        m_ptr = 0;
        e_rv = '0;
        e_hit = 1'b0;
        e_pte = '0;
        e_pt = '0;
        e_idx = 0;
        e_fd = 1'b0;
    endtask

    // Compare process: check, then advance the model across the next edge.
    initial begin
        logic [NP-1:0] eg;
        int            gp;
        int            p;
        logic          n_hit;
        int            n_idx;
        int            v;
        bit            kill;
        logic [VB-1:0] lv;
        model_reset();
        forever begin
            @(negedge clk);
            if (!reset) model_reset();
            eg = '0;
            gp = -1;
            if (reset && !fill_valid && !flush_valid) begin
                for (int k = 0; k < NP; k++) begin
                    p = (m_ptr + k) % NP;
                    if (gp < 0 && req_valid[p]) begin
                        gp = p;
                        eg[p] = 1'b1;
                    end
                end
            end
            chk("req_ready", 64'(req_ready), 64'(eg));
            chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
            chk("rsp_hit", 64'(rsp_hit), 64'(e_hit));
            chk("rsp_pte", rsp_pte, e_pte);
            chk("rsp_page_type", 64'(rsp_pt), 64'(e_pt));
            chk("flush_done", 64'(flush_done), 64'(e_fd));
            if (reset) begin
                n_hit = 1'b0;
                n_idx = 0;
                if (gp >= 0) begin
                    lv = req_vpn[gp*VB +: VB];
                    for (int i = NE - 1; i >= 0; i--) begin
                        if (m_v[i] && (m_asid[i] == req_asid || m_pte[i][5])
                            && vpn_eq(m_vpn[i], lv, m_pt[i])) begin
                            n_hit = 1'b1;
                            n_idx = i;
                        end
                    end
                    m_ptr = (gp + 1) % NP;
                end
                if (flush_valid) begin
                    for (int i = 0; i < NE; i++) begin
                        case (flush_mode)
                            2'd0: kill = 1'b1;
                            2'd1: kill = m_asid[i] == flush_asid && !m_pte[i][5];
                            2'd2: kill = vpn_eq(m_vpn[i], flush_vpn, m_pt[i]);
                            default: kill = vpn_eq(m_vpn[i], flush_vpn, m_pt[i])
                                         && m_asid[i] == flush_asid && !m_pte[i][5];
                        endcase
                        if (kill) m_v[i] = 1'b0;
                    end
                    if (e_hit) plru_touch(e_idx);
                end else if (fill_valid) begin
                    v = -1;
                    for (int i = NE - 1; i >= 0; i--) if (!m_v[i]) v = i;
                    if (v < 0) v = plru_victim();
                    m_v[v] = 1'b1;
                    m_vpn[v] = fill_vpn;
                    m_asid[v] = fill_asid;
                    m_pte[v] = fill_pte;
                    m_pt[v] = int'(fill_pt);
                    plru_touch(v);
                end else if (e_hit) begin
                    plru_touch(e_idx);
                end
                e_rv = eg;
                e_hit = n_hit;
                e_pte = n_hit ? m_pte[n_idx] : '0;
                e_pt = n_hit ? 2'(m_pt[n_idx]) : 2'd0;
                e_idx = n_idx;
                e_fd = flush_valid;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input int port, input logic [VB-1:0] vpn,
                          output logic hit, output logic [XL-1:0] pte,
                          output logic [1:0] pt);
        int n = 0;
        bit got = 1'b0;
        req_valid[port] = 1'b1;
        req_vpn[port*VB +: VB] = vpn;
        while (!got && n < 20) begin
            tick();
            n++;
            if (rsp_valid[port]) got = 1'b1;
        end
        req_valid[port] = 1'b0;
        hit = rsp_hit;
        pte = rsp_pte;
        pt = rsp_pt;
        if (!got) chk("lookup_timeout", 64'd0, 64'd1);
    endtask

    task automatic fill(input logic [VB-1:0] vpn, input logic [AB-1:0] asid,
                        input logic [XL-1:0] pte, input logic [1:0] pt);
        fill_valid = 1'b1;
        fill_vpn = vpn;
        fill_asid = asid;
        fill_pte = pte;
        fill_pt = pt;
        tick();
        fill_valid = 1'b0;
    endtask

    task automatic flush(input logic [1:0] mode, input logic [AB-1:0] asid,
                         input logic [VB-1:0] vpn);
        flush_valid = 1'b1;
        flush_mode = mode;
        flush_asid = asid;
        flush_vpn = vpn;
        tick();
        flush_valid = 1'b0;
        chk("flush_done_pulse", 64'(flush_done), 64'd1);
    endtask

    initial begin
        logic          h;
        logic [XL-1:0] pte;
        logic [1:0]    pt;
        logic [NP-1:0] gr [6];
        logic [NP-1:0] gexp [6];
        int            misses;
        logic [VB-1:0] missv;

        gexp[0] = 2'b01; gexp[1] = 2'b10; gexp[2] = 2'b01;
        gexp[3] = 2'b00; gexp[4] = 2'b10; gexp[5] = 2'b01;

        tick();
        req_valid = 2'b11;
        #1;
        chk("reset_ready", 64'(req_ready), 64'd0);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        req_valid = '0;
        tick();
        reset = 1'b1;
        tick();

        // empty table misses
        req_asid = 16'd3;
        lookup(0, 36'h12345, h, pte, pt);
        chk("t1_hit", 64'(h), 64'd0);
        chk("t1_pte", pte, 64'd0);

        fill(36'h12345, 16'd3, 64'h2000_04CF, 2'd0);
        lookup(1, 36'h12345, h, pte, pt);
        chk("t2_hit", 64'(h), 64'd1);
        chk("t2_pte", pte, 64'h2000_04CF);
        chk("t2_pt", 64'(pt), 64'd0);

        // megapage: low 9 VPN bits ignored
        fill(36'h00A00, 16'd3, 64'h3000_00CF, 2'd1);
        lookup(0, 36'h00BFF, h, pte, pt);
        chk("mega_in_hit", 64'(h), 64'd1);
        chk("mega_in_pt", 64'(pt), 64'd1);
        lookup(1, 36'h00C00, h, pte, pt);
        chk("mega_out_hit", 64'(h), 64'd0);

        // round robin with a fill stealing cycle 3
        req_vpn[0*VB +: VB] = 36'h3333;
        req_vpn[1*VB +: VB] = 36'h4444;
        req_valid = 2'b11;
        for (int c = 0; c < 6; c++) begin
            if (c == 3) begin
                fill_valid = 1'b1;
                fill_vpn = 36'h7777;
                fill_asid = 16'd9;
                fill_pte = 64'hCF;
                fill_pt = 2'd0;
            end
            #1;
            gr[c] = req_ready;
            tick();
            fill_valid = 1'b0;
        end
        req_valid = '0;
        tick();
        for (int c = 0; c < 6; c++) chk("rr_grant", 64'(gr[c]), 64'(gexp[c]));

        // flush by ASID keeps global entries
        req_asid = 16'd5;
        fill(36'h500, 16'd5, 64'hEF, 2'd0);
        fill(36'h501, 16'd5, 64'hCF, 2'd0);
        flush(2'd1, 16'd5, 36'h0);
        lookup(0, 36'h500, h, pte, pt);
        chk("fl_asid_global", 64'(h), 64'd1);
        lookup(0, 36'h501, h, pte, pt);
        chk("fl_asid_local", 64'(h), 64'd0);
        flush(2'd0, 16'd0, 36'h0);
        lookup(0, 36'h500, h, pte, pt);
        chk("fl_all_global", 64'(h), 64'd0);
        lookup(1, 36'h501, h, pte, pt);
        chk("fl_all_local", 64'(h), 64'd0);

        // flush by VPN, any ASID
        req_asid = 16'd7;
        fill(36'h600, 16'd7, 64'hCF, 2'd0);
        lookup(0, 36'h600, h, pte, pt);
        chk("fl_vpn_pre", 64'(h), 64'd1);
        flush(2'd2, 16'd0, 36'h600);
        lookup(0, 36'h600, h, pte, pt);
        chk("fl_vpn_post", 64'(h), 64'd0);

        // ASID+VPN flush spares a global entry
        fill(36'h700, 16'd7, 64'hEF, 2'd0);
        flush(2'd3, 16'd7, 36'h700);
        lookup(1, 36'h700, h, pte, pt);
        chk("fl_both_global", 64'(h), 64'd1);

        // flush and fill together: fill dropped
        flush_valid = 1'b1;
        flush_mode = 2'd0;
        fill_valid = 1'b1;
        fill_vpn = 36'h900;
        fill_asid = 16'd7;
        fill_pte = 64'hCF;
        fill_pt = 2'd0;
        tick();
        flush_valid = 1'b0;
        fill_valid = 1'b0;
        lookup(0, 36'h900, h, pte, pt);
        chk("flush_fill_drop", 64'(h), 64'd0);

        // full table: the 33rd fill evicts the PLRU victim (way 0)
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        req_asid = 16'd1;
        for (int i = 0; i <= NE; i++) fill(36'h1000 + 36'(i), 16'd1, 64'hCF, 2'd0);
        misses = 0;
        missv = '0;
        for (int i = 0; i <= NE; i++) begin
            lookup(0, 36'h1000 + 36'(i), h, pte, pt);
            if (!h) begin
                misses++;
                missv = 36'h1000 + 36'(i);
            end
        end
        chk("plru_miss_count", 64'(misses), 64'd1);
        chk("plru_victim_vpn", 64'(missv), 64'h1000);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
